// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh result reader: FSM states, default
// batch geometry, the FIFO payload layout and the writer's saturation codes.
package tanh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

  localparam logic [11:0] DEF_BASE_ADDR = 12'h200;
  localparam int          DEF_NUM_WORDS = 32'd256;
  localparam logic [11:0] DEF_ADDR_STEP = 12'd2;

  localparam logic [15:0] SAT_POS_CODE = 16'h7FEA;
  localparam logic [15:0] SAT_NEG_CODE = 16'h8016;

  // One FIFO entry: 16-bit result, 8-bit element index, last-element flag.
  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  idx;
    logic        last;
  } result_t;

  function automatic logic is_sat_code(input logic [15:0] value);
    return (value == SAT_POS_CODE) || (value == SAT_NEG_CODE);
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO holding returned results; the head entry drives the stream
// outputs directly from registers.
module result_skid_fifo
  import tanh_pkg::*;
(
  input  logic    clk,
  input  logic    reset_b,
  input  logic    push,
  input  result_t push_entry,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output result_t head
);

  result_t    mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  // Qualify requests: a full FIFO only accepts a push alongside a pop.
  always_comb begin
    push_ok_s = push && ((count_r != 2'd2) || pop);
    pop_ok_s  = pop && (count_r != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      mem_r[0] <= result_t'(25'd0);
      mem_r[1] <= result_t'(25'd0);
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/tanh_result_reader.sv
// Streams a batch of tanh results out of SRAM into a ready/valid interface.
// Optional out_sat flag port is enabled by defining TANH_READER_SAT_FLAG_EN.
module tanh_result_reader
  import tanh_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [11:0] ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        computation_done,
  output logic        sram_rd_en,
  output logic [11:0] sram_rd_address,
  input  logic [15:0] sram_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [7:0]  out_index,
  output logic        out_last,
`ifdef TANH_READER_SAT_FLAG_EN
  output logic        out_sat,
`endif
  output logic        reader_busy,
  output logic        reader_done
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  reader_state_e state_r;
  logic [7:0]    rd_idx_r;
  logic [11:0]   rd_addr_r;
  logic          inflight_r;
  logic [7:0]    inflight_idx_r;
  logic          busy_r;
  logic          done_r;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          pop_s;
  logic          rd_en_s;
  logic [1:0]    occ_s;
  logic [1:0]    pending_s;
  result_t       push_entry_s;
  result_t       head_s;

  // Read credit: a slot freed by this cycle's transfer can be refilled by a
  // read issued now, which is what allows one transfer per cycle.
  always_comb begin
    pop_s = !fifo_empty_s && out_ready;
    if (fifo_full_s) begin
      occ_s = 2'd2;
    end else if (fifo_empty_s) begin
      occ_s = 2'd0;
    end else begin
      occ_s = 2'd1;
    end
    pending_s         = occ_s - {1'b0, pop_s} + {1'b0, inflight_r};
    rd_en_s           = (state_r == ST_READ) && (pending_s < 2'd2);
    push_entry_s.data = sram_rd_data;
    push_entry_s.idx  = inflight_idx_r;
    push_entry_s.last = (inflight_idx_r == LAST_IDX);
  end

  // Batch control FSM with read counter, address and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r        <= ST_IDLE;
      rd_idx_r       <= 8'd0;
      rd_addr_r      <= 12'h000;
      inflight_r     <= 1'b0;
      inflight_idx_r <= 8'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      if (rd_en_s) begin
        inflight_idx_r <= rd_idx_r;
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (computation_done) begin
            state_r   <= ST_READ;
            rd_idx_r  <= 8'd0;
            rd_addr_r <= BASE_ADDR;
            busy_r    <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_en_s) begin
            // Final address is held rather than advanced past the batch.
            if (rd_idx_r == LAST_IDX) begin
              state_r <= ST_DRAIN;
            end else begin
              rd_idx_r  <= rd_idx_r + 8'd1;
              rd_addr_r <= rd_addr_r + ADDR_STEP;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && head_s.last) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  result_skid_fifo u_fifo (
    .clk        (clk),
    .reset_b    (reset_b),
    .push       (inflight_r),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .head       (head_s)
  );

  assign sram_rd_en      = rd_en_s;
  assign sram_rd_address = rd_addr_r;
  assign out_valid       = !fifo_empty_s;
  assign out_data        = head_s.data;
  assign out_index       = head_s.idx;
  assign out_last        = head_s.last;
  assign reader_busy     = busy_r;
  assign reader_done     = done_r;

`ifdef TANH_READER_SAT_FLAG_EN
  assign out_sat = out_valid && is_sat_code(head_s.data);
`endif

endmodule

// File: tb/tb_tanh_result_reader.sv
// Self-checking bench for tanh_result_reader: SRAM model plus a stream-level
// reference (word n at 0x200 + 2n appears in order with index n).
module tb_tanh_result_reader;

  logic        clk;
  logic        reset_b;
  logic        computation_done;
  logic        sram_rd_en;
  logic [11:0] sram_rd_address;
  logic [15:0] sram_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_index;
  logic        out_last;
  logic        reader_busy;
  logic        reader_done;
`ifdef TANH_READER_SAT_FLAG_EN
  logic        out_sat;
`endif

  tanh_result_reader dut (
    .clk              (clk),
    .reset_b          (reset_b),
    .computation_done (computation_done),
    .sram_rd_en       (sram_rd_en),
    .sram_rd_address  (sram_rd_address),
    .sram_rd_data     (sram_rd_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_index        (out_index),
    .out_last         (out_last),
`ifdef TANH_READER_SAT_FLAG_EN
    .out_sat          (out_sat),
`endif
    .reader_busy      (reader_busy),
    .reader_done      (reader_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM word array; read data appears the cycle after the enable.
  logic [15:0] sram_mem [0:2047];
  bit          sat_exp [0:255];
  initial sram_rd_data = 16'h0000;
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= sram_mem[sram_rd_address[11:1]];
  end

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  logic [15:0] got_data [$];
  logic [7:0]  got_idx [$];
  bit          got_last [$];
  int          got_cyc [$];
  logic [11:0] rd_addrs [$];
  int          done_pulses, done_cyc, stall_viol, max_outst, sat_viol;
  int          busy_cyc, valid_cyc;
  bit          busy_seen, valid_seen, prev_stall;
  logic [15:0] prev_data;
  logic [7:0]  prev_idx;
  logic        prev_last;

  task automatic clear_record();
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    rd_addrs.delete();
    done_pulses = 0; done_cyc = 0; stall_viol = 0; max_outst = 0; sat_viol = 0;
    busy_seen = 1'b0; valid_seen = 1'b0; prev_stall = 1'b0;
    busy_cyc = 0; valid_cyc = 0;
  endtask

  // kind 0: word n = n; kind 1: random words that are not saturation codes.
  task automatic preload(input int kind);
    logic [15:0] w;
    for (int a = 0; a < 2048; a++) sram_mem[a] = 16'($urandom);
    for (int n = 0; n < 256; n++) begin
      if (kind == 0) begin
        w = 16'(n);
      end else begin
        do w = 16'($urandom); while (w == 16'h7FEA || w == 16'h8016);
      end
      sram_mem[256 + n] = w;
      sat_exp[n] = 1'b0;
    end
  endtask

  // One cycle: drive inputs at the falling edge, then observe settled outputs.
  task automatic step(input logic rdy, input logic cd, input logic rb);
    @(negedge clk);
    out_ready = rdy; computation_done = cd; reset_b = rb;
    #1;
    cyc++;
    if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data ||
                       out_index !== prev_idx || out_last !== prev_last)) stall_viol++;
    if (rb) begin
      if (sram_rd_en === 1'b1) rd_addrs.push_back(sram_rd_address);
      if (out_valid === 1'b1 && out_ready) begin
        got_data.push_back(out_data); got_idx.push_back(out_index);
        got_last.push_back(out_last); got_cyc.push_back(cyc);
      end
      if (rd_addrs.size() - got_data.size() > max_outst) max_outst = rd_addrs.size() - got_data.size();
      if (out_valid === 1'b1 && !valid_seen) begin valid_seen = 1'b1; valid_cyc = cyc; end
`ifdef TANH_READER_SAT_FLAG_EN
      if (out_valid === 1'b1 && out_sat !== sat_exp[out_index]) sat_viol++;
`endif
    end
    if (reader_done === 1'b1) begin done_pulses++; done_cyc = cyc; end
    if (reader_busy === 1'b1 && !busy_seen) begin busy_seen = 1'b1; busy_cyc = cyc; end
    prev_stall = rb && (out_valid === 1'b1) && !rdy;
    prev_data = out_data; prev_idx = out_index; prev_last = out_last;
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready.
  task automatic run_batch(input int mode, input int budget, output bit timed_out);
    logic r;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      step(r, 1'b0, 1'b1);
      if (done_pulses != 0) begin timed_out = 1'b0; break; end
    end
  endtask

  // Element-wise distance between the recorded stream and the reference.
  function automatic int stream_errors();
    int e = 0;
    if (got_data.size() != 256) e++;
    for (int n = 0; n < got_data.size(); n++) begin
      if (got_data[n] !== sram_mem[256 + n]) e++;
      if (got_idx[n] !== 8'(n)) e++;
      if (got_last[n] !== (n == 255)) e++;
    end
    return e;
  endfunction

  function automatic int addr_errors();
    int e = 0;
    if (rd_addrs.size() != 256) e++;
    for (int n = 0; n < rd_addrs.size(); n++) begin
      if (rd_addrs[n] !== 12'(12'h200 + 2 * n)) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_data, out_index, out_last, sram_rd_en, sram_rd_address, reader_busy, reader_done} !== 41'd0)
      begin bad++; $display("FAIL reset_outputs: got %h want 0", {out_valid, out_data, out_index, out_last, sram_rd_en, sram_rd_address, reader_busy, reader_done}); end
    clear_record();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1);
    total++;
    if (busy_seen || rd_addrs.size() != 0 || valid_seen)
      begin bad++; $display("FAIL idle_quiet: busy=%0d reads=%0d valid=%0d want 0 0 0", busy_seen, rd_addrs.size(), valid_seen); end
  endtask

  task automatic test_full_rate();
    bit to;
    preload(0);
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    run_batch(0, 600, to);
    total++; if (to) begin bad++; $display("FAIL full_timeout: reader_done not seen, got %0d transfers", got_data.size()); end
    total++; if (stream_errors() != 0) begin bad++; $display("FAIL full_stream: %0d element errors over %0d transfers, want 0 over 256", stream_errors(), got_data.size()); end
    total++; if (addr_errors() != 0) begin bad++; $display("FAIL full_addrs: %0d address errors over %0d reads, want 0 over 256", addr_errors(), rd_addrs.size()); end
    total++; if (valid_cyc - busy_cyc != 2) begin bad++; $display("FAIL full_latency: got %0d want 2", valid_cyc - busy_cyc); end
    total++;
    if (got_cyc.size() != 256 || got_cyc[255] - got_cyc[0] != 255)
      begin bad++; $display("FAIL full_rate: %0d transfers spanning %0d cycles, want 256 over 255", got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1); end
    total++;
    if (done_pulses != 1 || got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1)
      begin bad++; $display("FAIL full_done: pulses=%0d at cycle %0d, want 1 pulse right after last transfer", done_pulses, done_cyc); end
    step(1'b1, 1'b0, 1'b1);
    total++; if (reader_done !== 1'b0 || sram_rd_address !== 12'h3FE)
      begin bad++; $display("FAIL full_after: done=%b addr=%h want 0 3fe", reader_done, sram_rd_address); end
  endtask

  task automatic test_toggle();
    bit to;
    preload(1);
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    run_batch(1, 1200, to);
    total++; if (to) begin bad++; $display("FAIL toggle_timeout: got %0d transfers", got_data.size()); end
    total++; if (stream_errors() != 0) begin bad++; $display("FAIL toggle_stream: %0d element errors over %0d transfers, want 0 over 256", stream_errors(), got_data.size()); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL toggle_stable: %0d stall changes, want 0", stall_viol); end
    total++; if (max_outst > 2) begin bad++; $display("FAIL toggle_outstanding: max %0d want <= 2", max_outst); end
    total++; if (done_pulses != 1) begin bad++; $display("FAIL toggle_done: pulses=%0d want 1", done_pulses); end
  endtask

  task automatic test_stall_start();
    bit to;
    preload(1);
    clear_record();
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b1);
    total++;
    if (rd_addrs.size() != 2 || rd_addrs[0] !== 12'h200 || rd_addrs[1] !== 12'h202)
      begin bad++; $display("FAIL stall_reads: %0d reads (first %h %h), want 2 reads 200 202", rd_addrs.size(), (rd_addrs.size() > 0) ? rd_addrs[0] : 12'hfff, (rd_addrs.size() > 1) ? rd_addrs[1] : 12'hfff); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_hold: %0d changes while stalled, want 0", stall_viol); end
    run_batch(2, 1500, to);
    total++; if (to || stream_errors() != 0)
      begin bad++; $display("FAIL stall_stream: timeout=%0d errors=%0d transfers=%0d, want 0 0 256", to, stream_errors(), got_data.size()); end
    total++; if (addr_errors() != 0) begin bad++; $display("FAIL stall_addrs: %0d address errors, want 0", addr_errors()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    preload(1);
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 400 && got_data.size() < 100; k++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    total++;
    if ({out_valid, out_data, out_index, out_last, sram_rd_en, sram_rd_address, reader_busy, reader_done} !== 41'd0)
      begin bad++; $display("FAIL midreset_outputs: got %h want 0", {out_valid, out_data, out_index, out_last, sram_rd_en, sram_rd_address, reader_busy, reader_done}); end
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1);
    total++; if (done_pulses != 0 || got_data.size() != 100 || reader_busy !== 1'b0)
      begin bad++; $display("FAIL midreset_abort: done=%0d transfers=%0d busy=%b want 0 100 0", done_pulses, got_data.size(), reader_busy); end
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    run_batch(2, 1500, to);
    total++; if (to || stream_errors() != 0 || addr_errors() != 0)
      begin bad++; $display("FAIL midreset_restart: timeout=%0d stream_err=%0d addr_err=%0d want 0 0 0", to, stream_errors(), addr_errors()); end
  endtask

  task automatic test_cd_ignored();
    logic r, cdv;
    bit   cd_on_done = 1'b0;
    preload(1);
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 1500 && done_pulses == 0; k++) begin
      r   = 1'($urandom_range(0, 1));
      cdv = (k == 20) || (got_data.size() == 256);
      step(r, cdv, 1'b1);
      if (reader_done === 1'b1 && computation_done) cd_on_done = 1'b1;
    end
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b1);
    total++; if (!cd_on_done) begin bad++; $display("FAIL cd_overlap: start strobe with reader_done seen=%0d want 1", cd_on_done); end
    total++; if (stream_errors() != 0 || rd_addrs.size() != 256)
      begin bad++; $display("FAIL cd_ignored: transfers=%0d reads=%0d errors=%0d want 256 256 0", got_data.size(), rd_addrs.size(), stream_errors()); end
    total++; if (reader_busy !== 1'b0 || out_valid !== 1'b0 || done_pulses != 1 || sram_rd_address !== 12'h3FE)
      begin bad++; $display("FAIL cd_idle: busy=%b valid=%b done=%0d addr=%h want 0 0 1 3fe", reader_busy, out_valid, done_pulses, sram_rd_address); end
  endtask

`ifdef TANH_READER_SAT_FLAG_EN
  task automatic test_sat();
    bit to;
    preload(1);
    sram_mem[256 + 3] = 16'h7FEA; sat_exp[3] = 1'b1;
    sram_mem[256 + 7] = 16'h8016; sat_exp[7] = 1'b1;
    clear_record();
    step(1'b1, 1'b1, 1'b1);
    run_batch(2, 1500, to);
    total++; if (to || stream_errors() != 0)
      begin bad++; $display("FAIL sat_stream: timeout=%0d errors=%0d want 0 0", to, stream_errors()); end
    total++; if (sat_viol != 0) begin bad++; $display("FAIL sat_flag: %0d wrong out_sat cycles, want 0", sat_viol); end
  endtask
`endif

  initial begin
    reset_b = 1'b0; out_ready = 1'b0; computation_done = 1'b0;
    test_reset();
    test_full_rate();
    test_toggle();
    test_stall_start();
    test_reset_mid();
    test_cd_ignored();
`ifdef TANH_READER_SAT_FLAG_EN
    test_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tanh_result_reader.md
TANH_RESULT_READER -- requirements
Module: tanh_result_reader

Interface
REQ-001 Parameter BASE_ADDR, 12'h200, SRAM byte address of result word 0.
REQ-002 Parameter NUM_WORDS, 256, number of 16-bit results per batch.
REQ-003 Parameter ADDR_STEP, 2, address increment per word.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset_b  input  1  synchronous, active-low reset.
REQ-006 computation_done  input  1  start strobe from the tanh writer; sampled high starts a batch.
REQ-007 sram_rd_en  output  1  SRAM read enable.
REQ-008 sram_rd_address  output  12  SRAM read address.
REQ-009 sram_rd_data  input  16  SRAM read data, valid exactly 1 cycle after sram_rd_en.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-012 out_data  output  16  signed Q1.15 tanh result.
REQ-013 out_index  output  8  element index 0..NUM_WORDS-1 of out_data.
REQ-014 out_last  output  1  high with the element at index NUM_WORDS-1.
REQ-015 reader_busy  output  1  high from start until the final transfer.
REQ-016 reader_done  output  1  one-cycle pulse after the final transfer.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, DONE.
REQ-018 IDLE->READ when computation_done=1; read counter and index are cleared on this transition.
REQ-019 In READ, sram_rd_en is asserted only when FIFO occupancy plus in-flight reads is below 2; the address is BASE_ADDR + ADDR_STEP*n for n = 0..NUM_WORDS-1.
REQ-020 READ->DRAIN the cycle after the read for n = NUM_WORDS-1 issues; no further reads follow.
REQ-021 DRAIN->DONE on the transfer with out_last=1; DONE asserts reader_done for one cycle and then returns to IDLE.
REQ-022 Returned data enters a 2-entry FIFO; its head drives out_data, out_index and out_last.
REQ-023 Data is never dropped: out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
REQ-024 With out_ready held at 1, the block sustains one transfer per cycle after a 2-cycle initial latency from start to the first out_valid.
REQ-025 computation_done is ignored outside IDLE, including when it arrives in the same cycle as reader_done.
REQ-026 Data is passed through unchanged; no arithmetic is applied to it.
REQ-027 The address counter saturates at its final value and never wraps past BASE_ADDR + ADDR_STEP*(NUM_WORDS-1).

Reset
REQ-028 With reset_b=0 at a clock edge: state becomes IDLE, the FIFO is emptied, the in-flight flag is cleared, and all outputs go to 0, including sram_rd_address=12'h000.
REQ-029 Reset mid-batch aborts the batch; no reader_done is produced, and after reset the block waits for a new computation_done.

Configuration
REQ-030 TANH_READER_SAT_FLAG_EN defined: adds an output port out_sat (1 bit), high with a FIFO entry whose out_data equals 16'h7FEA or 16'h8016 (the writer's saturation codes).
REQ-031 TANH_READER_SAT_FLAG_EN undefined: the out_sat port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Package tanh_pkg holds the FSM state enum, the BASE_ADDR/NUM_WORDS/ADDR_STEP defaults, and the saturation constants 16'h7FEA and 16'h8016.
REQ-033 The 2-entry FIFO is sub-module result_skid_fifo (push, pop, full, empty, 25-bit payload = data, index, last), instantiated once.

Verification
REQ-034 Preload 0x200..0x3FE with word n=n; pulse computation_done; hold out_ready=1 -> 256 transfers in consecutive cycles, out_data=n, out_index=n, out_last only at n=255, reader_done 1 cycle after.
REQ-035 Same preload; toggle out_ready 1/0 each cycle -> same sequence in order, no loss or duplicates, outputs stable while stalled, at most 2 reads outstanding.
REQ-036 Hold out_ready=0 for 50 cycles after start -> exactly 2 reads issued (0x200, 0x202); after release the stream completes correctly.
REQ-037 Pulse reset_b=0 at transfer 100 -> all outputs 0 the next cycle, no reader_done; a new computation_done restarts from address 0x200 with index 0.
REQ-038 Pulse computation_done during READ and again in the reader_done cycle -> no restart, exactly 256 transfers, state IDLE.
REQ-039 With TANH_READER_SAT_FLAG_EN defined, preload words 3=0x7FEA and 7=0x8016 -> out_sat=1 only at indices 3 and 7.
